// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side handshake bundle for uart_tx_arbiter.
// master = arbiter view, slave = requesters/uart_tx view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int W_MESSAGE = 8
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*W_MESSAGE-1:0] req_data;
    logic [N_REQ-1:0]           req_ready;
    logic                       tx_ready;
    logic [W_MESSAGE-1:0]       message;
    logic                       tx_busy;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_ready, message
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_ready, message
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to abort a start request that uart_tx never acknowledges.
//
// state     | meaning
// IDLE      | no frame owned; grant when uart_tx idle and any request valid
// START     | tx_ready high, waiting for uart_tx to raise tx_busy
// WAIT_DONE | frame in progress, waiting for tx_busy to fall
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int W_MESSAGE     = 8,
    parameter int START_TIMEOUT = 64,
    localparam int W_ID         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                arstn,
    uart_tx_arbiter_if.master   bus,
    output logic [W_ID-1:0]     grant_id,
    output logic                active,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic                   tx_ready_q, tx_ready_nxt;
    logic [W_MESSAGE-1:0]   message_q, message_nxt;
    logic [W_ID-1:0]        grant_id_nxt;
    logic [W_ID-1:0]        rr_ptr, rr_ptr_nxt;

    logic                   found;
    logic [W_ID-1:0]        winner;
    logic [W_ID-1:0]        winner_inc;
    int                     scan_idx;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = W_ID'(scan_idx);
            end
        end
    end

    assign winner_inc = (winner == W_ID'(N_REQ - 1)) ? '0 : winner + W_ID'(1);

    // Gated by arstn so nothing is accepted while the block is held in reset.
    always_comb begin
        bus.req_ready = '0;
        if (arstn && state == IDLE && !bus.tx_busy && found) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int W_TMO = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    logic [W_TMO-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             timeout_err_nxt;
`endif

    always_comb begin
        state_nxt    = state;
        tx_ready_nxt = tx_ready_q;
        message_nxt  = message_q;
        grant_id_nxt = grant_id;
        rr_ptr_nxt   = rr_ptr;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_cnt_nxt     = tmo_cnt;
        timeout_err_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!bus.tx_busy && found) begin
                    message_nxt  = bus.req_data[int'(winner)*W_MESSAGE +: W_MESSAGE];
                    grant_id_nxt = winner;
                    rr_ptr_nxt   = winner_inc;
                    tx_ready_nxt = 1'b1;
                    state_nxt    = START;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_nxt  = W_TMO'(START_TIMEOUT - 1);
`endif
                end
            end
            START: begin
                if (bus.tx_busy) begin
                    tx_ready_nxt = 1'b0;
                    state_nxt    = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    tx_ready_nxt    = 1'b0;
                    timeout_err_nxt = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - W_TMO'(1);
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= IDLE;
            tx_ready_q <= 1'b0;
            message_q  <= '0;
            grant_id   <= '0;
            rr_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            tx_ready_q <= tx_ready_nxt;
            message_q  <= message_nxt;
            grant_id   <= grant_id_nxt;
            rr_ptr     <= rr_ptr_nxt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt     <= tmo_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign bus.tx_ready = tx_ready_q;
    assign bus.message  = message_q;
    assign active       = (state != IDLE);

endmodule
